alu_seq: RTL and testbench

- 8-bit execute-stage ALU that feeds the flag register.
- Accepts an opcode and two operands on a start strobe, then produces a 9-bit result: bit 8 is the carry/borrow/overflow bit.
- Raises a one-cycle `alu_2_data` strobe when the result is valid. The flag register and the register-file writeback both consume this strobe.
- Single-cycle ops complete in 1 cycle. MUL is an iterative shift-add taking `DATA_W` cycles, with a busy handshake.

---
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU feeding the flag register and writeback.
// Ports: clk, rst (async active-low), start/opcode/op_a/op_b/carry_in in;
//        busy (MUL in flight), alu_output (carry + data), alu_2_data strobe out.
module alu_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              carry_in,
    output logic              busy,
    output logic [DATA_W:0]   alu_output,
    output logic              alu_2_data
);

    localparam int RW = DATA_W + 1;
    localparam int PW = 2 * DATA_W;
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_RLC  = 4'hC;
    localparam logic [3:0] OP_RRC  = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;
    localparam logic [3:0] OP_PASS = 4'hF;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [PW-1:0]     acc, acc_n;
    logic [PW-1:0]     mcand, mcand_n;
    logic [PW-1:0]     acc_sum;
    logic [DATA_W-1:0] mplier, mplier_n;
    logic [RW-1:0]     res;
    logic [RW-1:0]     a9, b9, c9;
    logic [RW-1:0]     out_n;
    logic              strobe_n;
    logic              last_iter;

    assign a9 = {1'b0, op_a};
    assign b9 = {1'b0, op_b};
    assign c9 = {{DATA_W{1'b0}}, carry_in};

    // Single-cycle datapath; 9-bit wrap gives carry/borrow in the top bit.
    always_comb begin
        res = '0;
        unique case (opcode)
            OP_ADD:  res = a9 + b9;
            OP_ADC:  res = a9 + b9 + c9;
            OP_SUB:  res = a9 - b9;
            OP_SBB:  res = a9 - b9 - c9;
            OP_AND:  res = a9 & b9;
            OP_OR:   res = a9 | b9;
            OP_XOR:  res = a9 ^ b9;
            OP_NOT:  res = {1'b0, ~op_a};
            OP_INC:  res = a9 + RW'(1);
            OP_DEC:  res = a9 - RW'(1);
            OP_SHL:  res = {op_a[DATA_W-1], op_a[DATA_W-2:0], 1'b0};
            OP_SHR:  res = {op_a[0], 1'b0, op_a[DATA_W-1:1]};
            OP_RLC:  res = {op_a[DATA_W-1], op_a[DATA_W-2:0], carry_in};
            OP_RRC:  res = {op_a[0], carry_in, op_a[DATA_W-1:1]};
            OP_MUL:  res = '0;
            OP_PASS: res = b9;
            default: res = '0;
        endcase
    end

    assign acc_sum   = acc + (mplier[0] ? mcand : '0);
    assign last_iter = (cnt == CW'(DATA_W - 1));
    assign busy      = (state == S_MUL);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        out_n    = alu_output;
        strobe_n = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        mcand_n  = {{DATA_W{1'b0}}, op_a};
                        mplier_n = op_b;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = S_MUL;
                    end else begin
                        out_n    = res;
                        strobe_n = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_n    = acc_sum;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + CW'(1);
                if (last_iter) begin
                    // Any high product bit saturates into the overflow flag.
                    out_n    = {|acc_sum[PW-1:DATA_W], acc_sum[DATA_W-1:0]};
                    strobe_n = 1'b1;
                    cnt_n    = '0;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            alu_output <= '0;
            alu_2_data <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            acc        <= acc_n;
            mcand      <= mcand_n;
            mplier     <= mplier_n;
            alu_output <= out_n;
            alu_2_data <= strobe_n;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq.
// Drives and samples 1 ns after each rising edge.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] opcode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       carry_in;
    logic       busy;
    logic [8:0] alu_output;
    logic       alu_2_data;

    int n_cmp;
    int n_bad;

    alu_seq #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .op_a       (op_a),
        .op_b       (op_b),
        .carry_in   (carry_in),
        .busy       (busy),
        .alu_output (alu_output),
        .alu_2_data (alu_2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
        opcode   = op;
        op_a     = a;
        op_b     = b;
        carry_in = c;
        start    = 1'b1;
    endtask

    // One single-cycle op: result and strobe right after the accept edge.
    task automatic one_op(input string tag, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [8:0] exp);
        drive(op, a, b, c);
        tick();
        start = 1'b0;
        chk(tag, 16'(alu_output), 16'(exp));
        chk({tag, "_stb"}, 16'(alu_2_data), 16'd1);
    endtask

    // MUL with optional ignored ADD pulse mid-flight.
    task automatic run_mul(input string tag, input logic [7:0] a,
                           input logic [7:0] b, input logic [8:0] exp,
                           input bit poke);
        int nb;
        int ns;
        logic [8:0] got;
        logic busy_at_stb;
        nb = 0;
        ns = 0;
        got = '0;
        busy_at_stb = 1'b1;
        drive(4'hE, a, b, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) nb++;
            if (alu_2_data) begin
                ns++;
                got = alu_output;
                busy_at_stb = busy;
            end
            if (poke && i == 3) drive(4'h0, 8'h01, 8'h01, 1'b1);
            if (poke && i == 4) start = 1'b0;
            tick();
        end
        chk({tag, "_busy_cycles"}, 16'(nb), 16'd8);
        chk({tag, "_strobes"}, 16'(ns), 16'd1);
        chk({tag, "_res"}, 16'(got), 16'(exp));
        chk({tag, "_busy_at_stb"}, 16'(busy_at_stb), 16'd0);
    endtask

    initial begin
        int ns;
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        start    = 1'b0;
        opcode   = 4'h0;
        op_a     = 8'h00;
        op_b     = 8'h00;
        carry_in = 1'b0;

        tick();
        tick();
        chk("rst_out", 16'(alu_output), 16'h000);
        chk("rst_stb", 16'(alu_2_data), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst = 1'b1;
        tick();

        one_op("add_ff_01", 4'h0, 8'hFF, 8'h01, 1'b0, 9'h100);
        chk("add_busy", 16'(busy), 16'd0);
        tick();
        chk("add_stb_once", 16'(alu_2_data), 16'd0);
        chk("add_hold", 16'(alu_output), 16'h100);

        drive(4'h2, 8'h05, 8'h07, 1'b0);
        tick();
        chk("sub", 16'(alu_output), 16'h1FE);
        chk("sub_stb", 16'(alu_2_data), 16'd1);
        drive(4'h3, 8'h10, 8'h01, 1'b1);
        tick();
        start = 1'b0;
        chk("sbb", 16'(alu_output), 16'h00E);
        chk("sbb_stb", 16'(alu_2_data), 16'd1);
        tick();
        chk("sbb_stb_low", 16'(alu_2_data), 16'd0);

        run_mul("mul_0f_11", 8'h0F, 8'h11, 9'h0FF, 1'b0);
        run_mul("mul_10_10", 8'h10, 8'h10, 9'h100, 1'b0);
        run_mul("mul_poke", 8'h0F, 8'h11, 9'h0FF, 1'b1);
        one_op("add_after", 4'h0, 8'h01, 8'h01, 1'b0, 9'h002);
        tick();

        // Reset during iteration 4 of a MUL.
        drive(4'hE, 8'h0F, 8'h11, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy", 16'(busy), 16'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_stb", 16'(alu_2_data), 16'd0);
        chk("arst_out", 16'(alu_output), 16'h000);
        tick();
        rst = 1'b1;
        ns = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (alu_2_data) ns++;
        end
        chk("post_rst_strobes", 16'(ns), 16'd0);

        one_op("rlc", 4'hC, 8'h80, 8'h00, 1'b1, 9'h101);
        one_op("rrc", 4'hD, 8'h01, 8'h00, 1'b0, 9'h100);
        one_op("shr", 4'hB, 8'h03, 8'h00, 1'b0, 9'h101);
        one_op("dec", 4'h9, 8'h00, 8'h00, 1'b0, 9'h1FF);
        one_op("shl", 4'hA, 8'h81, 8'h00, 1'b0, 9'h102);
        one_op("inc", 4'h8, 8'hFF, 8'h00, 1'b0, 9'h100);
        one_op("adc", 4'h1, 8'h7F, 8'h80, 1'b1, 9'h100);
        one_op("and", 4'h4, 8'hF0, 8'h3C, 1'b1, 9'h030);
        one_op("or", 4'h5, 8'hF0, 8'h0C, 1'b0, 9'h0FC);
        one_op("xor", 4'h6, 8'hFF, 8'h0F, 1'b0, 9'h0F0);
        one_op("not", 4'h7, 8'h5A, 8'h00, 1'b1, 9'h0A5);
        one_op("pass", 4'hF, 8'h12, 8'h34, 1'b1, 9'h034);
        tick();
        chk("final_stb_low", 16'(alu_2_data), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
